neighbour_window: RTL and testbench

//   Raster-order neighbourhood generator for connected-component labelling.
//   For each incoming pixel it presents the labels of its four already-scanned

---
 rtl/neighbour_window.sv | 102 ++++++++++
 tb/tb_neighbour_window.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/neighbour_window.sv
// ---------------------------------------------------------------------------
// neighbour_window
//
// Raster-order neighbourhood generator for connected-component labelling.
// For the current pixel (x,y) it presents the labels of the four neighbours
// that have already been scanned:
//   A = (x-1,y-1)   B = (x,y-1)   C = (x+1,y-1)   D = (x-1,y)
// The label resolved downstream for the current pixel comes back on lbl_in
// in the same cycle and is shifted into a one-line delay buffer.
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-high; clears position and all stored labels
//   en      current pixel valid; all state advances only when high
//   sof     with en: current pixel is (0,0) (resyncs the raster counters)
//   lbl_in  resolved label of the current pixel
//   A,B,C,D neighbour labels, 0 where the neighbour lies outside the image
//   x, y    position of the current pixel
//   eol     current pixel is the last of its line
//   eof     current pixel is the last of the frame
// ---------------------------------------------------------------------------
`ifndef LBL_WIDTH
`define LBL_WIDTH 8
`endif

module neighbour_window #(
  parameter int WIDTH      = `LBL_WIDTH,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          sof,
  input  logic [WIDTH-1:0]              lbl_in,
  output logic [WIDTH-1:0]              A,
  output logic [WIDTH-1:0]              B,
  output logic [WIDTH-1:0]              C,
  output logic [WIDTH-1:0]              D,
  output logic [$clog2(IMG_WIDTH)-1:0]  x,
  output logic [$clog2(IMG_HEIGHT)-1:0] y,
  output logic                          eol,
  output logic                          eof
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  // sr[k] holds the label seen k+1 accepted pixels ago.
  logic [WIDTH-1:0] sr [0:IMG_WIDTH];

  logic restart;
  logic first_row;
  logic first_col;

  // A start-of-frame pixel is shown as (0,0) in the very cycle it arrives,
  // so the visible position is the registered one overridden by en&&sof.
  assign restart   = en & sof;
  assign x         = restart ? '0 : x_q;
  assign y         = restart ? '0 : y_q;
  assign eol       = (x == X_LAST);
  assign eof       = eol && (y == Y_LAST);
  assign first_row = (y == '0);
  assign first_col = (x == '0);

  // Masking at the image border also hides whatever the previous frame left
  // in the delay line: row 0 of a new frame never reads the line above.
  assign A = (first_row || first_col) ? '0 : sr[IMG_WIDTH];
  assign B = first_row                ? '0 : sr[IMG_WIDTH-1];
  assign C = (first_row || eol)       ? '0 : sr[IMG_WIDTH-2];
  assign D = first_col                ? '0 : sr[0];

  // NOTE: every register here is updated with <= so all entries of the delay
  // line read their neighbour's pre-edge value; blocking = would collapse the
  // shift into a single copy of lbl_in.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      // NOTE: the whole line buffer is cleared on reset so that no label from
      // before the reset can ever appear on a tap; this forces a flop-based
      // buffer rather than a RAM without a reset port.
      for (int i = 0; i <= IMG_WIDTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= lbl_in;
      for (int i = 1; i <= IMG_WIDTH; i++) sr[i] <= sr[i-1];
      // Advance from the visible position so a sof pixel continues at (1,0).
      if (eol) begin
        x_q <= '0;
        y_q <= eof ? '0 : y + YW'(1);
      end else begin
        x_q <= x + XW'(1);
        y_q <= y;
      end
    end
  end

endmodule

// File: tb/tb_neighbour_window.sv
// ---------------------------------------------------------------------------
// tb_neighbour_window
//
// Directed bench for neighbour_window at IMG_WIDTH=4, IMG_HEIGHT=3.
// A 2-D image model records every accepted label at its (x,y) position and
// derives the expected neighbours from it; expectations are queued when the
// inputs are driven and compared at the following falling edge.
// ---------------------------------------------------------------------------
module tb_neighbour_window;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int LW = 8;

  typedef struct {
    logic [LW-1:0] a;
    logic [LW-1:0] b;
    logic [LW-1:0] c;
    logic [LW-1:0] d;
    int            x;
    int            y;
    logic          eol;
    logic          eof;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          sof;
  logic [LW-1:0] lbl_in;
  logic [LW-1:0] A, B, C, D;
  logic [1:0]    x;
  logic [1:0]    y;
  logic          eol;
  logic          eof;

  neighbour_window #(.WIDTH(LW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .en(en), .sof(sof), .lbl_in(lbl_in),
    .A(A), .B(B), .C(C), .D(D), .x(x), .y(y), .eol(eol), .eof(eof)
  );

  always #5 clk = ~clk;

  exp_t          sb[$];
  logic [LW-1:0] mem [0:H-1][0:W-1];
  int            mx, my;
  int            base;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    check({tag, " A"},   32'(A),   32'(e.a));
    check({tag, " B"},   32'(B),   32'(e.b));
    check({tag, " C"},   32'(C),   32'(e.c));
    check({tag, " D"},   32'(D),   32'(e.d));
    check({tag, " x"},   32'(x),   32'(e.x));
    check({tag, " y"},   32'(y),   32'(e.y));
    check({tag, " eol"}, 32'(eol), 32'(e.eol));
    check({tag, " eof"}, 32'(eof), 32'(e.eof));
  endtask

  // One pixel slot. Called #1 after a rising edge; returns #1 after the next.
  // The label fed back is base + raster index of the visible position.
  task automatic step(input string tag, input logic e, input logic s);
    exp_t ex;
    exp_t got;
    int px, py;
    logic [LW-1:0] l;
    px = (e && s) ? 0 : mx;
    py = (e && s) ? 0 : my;
    l  = e ? LW'(base + py * W + px) : 8'hEE;
    en = e; sof = s; lbl_in = l;

    ex.a = '0; ex.b = '0; ex.c = '0; ex.d = '0;
    if (py > 0 && px > 0)     ex.a = mem[py-1][px-1];
    if (py > 0)               ex.b = mem[py-1][px];
    if (py > 0 && px < W - 1) ex.c = mem[py-1][px+1];
    if (px > 0)               ex.d = mem[py][px-1];
    ex.x   = px;
    ex.y   = py;
    ex.eol = (px == W - 1);
    ex.eof = (px == W - 1) && (py == H - 1);
    sb.push_back(ex);

    @(negedge clk);
    got = sb.pop_front();
    compare_outputs(tag, got);

    @(posedge clk); #1;
    if (e) begin
      mem[py][px] = l;
      if (px == W - 1) begin
        mx = 0;
        my = (py == H - 1) ? 0 : py + 1;
      end else begin
        mx = px + 1;
        my = py;
      end
    end
  endtask

  task automatic pixels(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0);
  endtask

  // Reset held for one edge with en/sof high to show reset takes priority.
  task automatic do_reset(input string tag);
    exp_t zero;
    reset = 1'b1; en = 1'b1; sof = 1'b1; lbl_in = 8'hAA;
    @(posedge clk); #1;
    reset = 1'b0; en = 1'b0; sof = 1'b0;
    mx = 0; my = 0;
    zero.a = '0; zero.b = '0; zero.c = '0; zero.d = '0;
    zero.x = 0; zero.y = 0; zero.eol = 1'b0; zero.eof = 1'b0;
    sb.push_back(zero);
    @(negedge clk);
    compare_outputs(tag, sb.pop_front());
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sof = 1'b0; lbl_in = '0;
    mx = 0; my = 0; base = 10;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) mem[r][c] = '0;

    // Reset state.
    do_reset("reset");

    // Frame 1: row 0, then row 1 up to (2,1).
    pixels("f1_row0", W);
    pixels("f1_row1", 2);
    // Stall at (2,1): everything must hold.
    for (int i = 0; i < 5; i++) step("stall", 1'b0, 1'b0);
    // sof without en is ignored.
    step("sof_no_en", 1'b0, 1'b1);
    // Finish frame 1, including eof at (3,2).
    pixels("f1_rest", 2 + W);

    // Frame 2 wraps naturally; stale frame-1 labels must stay masked.
    base = 50;
    pixels("f2_wrap", W + 2);

    // Mid-frame sof at (2,1): restart as (0,0), then continue at (1,0).
    base = 100;
    step("sof", 1'b1, 1'b1);
    pixels("f3_after_sof", (W - 1) + W + 2);

    // Reset mid-row 2, then a full new frame plus the start of the next.
    do_reset("reset_mid");
    base = 150;
    pixels("f4", W * H + W + 1);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
